// File: rtl/call_arbiter_pkg.sv
// Shared types and sizes for the call arbiter: FSM encoding, subscriber count, counter widths.
package call_arbiter_pkg;

  localparam int unsigned NSUB             = 4;
  localparam int unsigned OWN_W            = 2;
  localparam int unsigned CNT_W            = 8;
  localparam int unsigned WAIT_W           = 3;
  localparam int unsigned WAIT_MAX_DEFAULT = 7;

  typedef enum logic [2:0] {
    ST_ARB    = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  // Saturating increment for the per-subscriber call counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : CNT_W'(v + CNT_W'(1));
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set req bit searching from last+1, wrapping to last.
module rr_pick4
  import call_arbiter_pkg::*;
(
  input  logic [NSUB-1:0]  req,
  input  logic [OWN_W-1:0] last,
  output logic [OWN_W-1:0] idx_c,
  output logic             valid_c
);

  always_comb begin
    idx_c   = last;
    valid_c = 1'b0;
    for (int unsigned k = 1; k <= NSUB; k++) begin
      if (!valid_c && req[last + OWN_W'(k)]) begin
        idx_c   = last + OWN_W'(k);
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/call_arbiter.sv
// Arbitrates four subscribers onto one shared telephone line and tracks connected calls.
module call_arbiter
  import call_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSUB-1:0]         req,
  input  logic [NSUB-1:0]         hangup,
  input  logic                    lineIdle,
  output logic                    startCall,
  output logic                    endCallCaller,
  output logic [NSUB-1:0]         grant,
  output logic [OWN_W-1:0]        owner,
  output logic                    busy,
  output logic [NSUB*CNT_W-1:0]   callCnt
);

  state_e                         state_q, state_d;
  logic [NSUB-1:0]                grant_q, grant_d;
  logic [OWN_W-1:0]               owner_q, owner_d;
  logic [WAIT_W-1:0]              wait_q, wait_d;
  logic [NSUB-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic                           start_q, start_d;
  logic                           end_q, end_d;
  logic                           busy_q, busy_d;
  logic [OWN_W-1:0]               pick_idx;
  logic                           pick_valid;

  rr_pick4 u_pick (
    .req     (req),
    .last    (owner_q),
    .idx_c   (pick_idx),
    .valid_c (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARB;
      grant_q <= '0;
      owner_q <= OWN_W'(NSUB - 1);
      wait_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
    end
  end

  // Next state and registered outputs; pulses default low so they last one cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    end_d   = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        grant_d = '0;
        if (lineIdle && pick_valid) begin
          owner_d = pick_idx;
          grant_d = NSUB'(1) << pick_idx;
          start_d = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!lineIdle) begin
          cnt_d[owner_q] = sat_inc(cnt_q[owner_q]);
          state_d        = ST_ACTIVE;
        end else if (wait_q == WAIT_W'(WAIT_MAX)) begin
          grant_d = '0;
          state_d = ST_ARB;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_ACTIVE: begin
        // A line that went idle on its own takes priority over the owner hanging up.
        if (lineIdle) begin
          grant_d = '0;
          state_d = ST_ARB;
        end else if (hangup[owner_q] || !req[owner_q]) begin
          end_d   = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (lineIdle) begin
          grant_d = '0;
          state_d = ST_ARB;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_ARB;
      end
    endcase
    busy_d = (state_d != ST_ARB);
  end

  assign startCall     = start_q;
  assign endCallCaller = end_q;
  assign grant         = grant_q;
  assign owner         = owner_q;
  assign busy          = busy_q;
  assign callCnt       = cnt_q;

endmodule

// File: tb/tb_call_arbiter.sv
// Scoreboard bench for call_arbiter: stimulus pushes model predictions, a monitor pops and compares.
module tb_call_arbiter;

  localparam int WAIT_MAX = 7;
  localparam int FREE  = 0;
  localparam int DIAL  = 1;
  localparam int RING  = 2;
  localparam int TALK  = 3;
  localparam int CLEAR = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  hangup;
  logic        line_idle;
  logic        start_call;
  logic        end_call;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic [31:0] call_cnt;

  typedef struct {
    logic [40:0] v;
    int          tag;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;
  bit   stim_done = 1'b0;

  // Reference model: call phase, current owner, unsaturated call tallies.
  int m_phase;
  int m_owner;
  int m_idle_waits;
  int m_calls[4];
  bit m_start;
  bit m_end;

  call_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .hangup        (hangup),
    .lineIdle      (line_idle),
    .startCall     (start_call),
    .endCallCaller (end_call),
    .grant         (grant),
    .owner         (owner),
    .busy          (busy),
    .callCnt       (call_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string tag_name(input int t);
    case (t)
      1: return "directed";
      2: return "timeout";
      3: return "random";
      4: return "saturate";
      5: return "reset_mid_call";
      default: return "other";
    endcase
  endfunction

  task automatic model_step(input bit r, input logic [3:0] rq, input logic [3:0] hu, input bit idle);
    m_start = 1'b0;
    m_end   = 1'b0;
    if (r) begin
      m_phase      = FREE;
      m_owner      = 3;
      m_idle_waits = 0;
      for (int i = 0; i < 4; i++) m_calls[i] = 0;
      return;
    end
    case (m_phase)
      FREE: begin
        if (idle && rq != 4'b0) begin
          for (int k = 1; k <= 4; k++) begin
            if (m_phase == FREE && rq[(m_owner + k) % 4]) begin
              m_owner = (m_owner + k) % 4;
              m_phase = DIAL;
            end
          end
          m_start      = 1'b1;
          m_idle_waits = 0;
        end
      end
      DIAL: m_phase = RING;
      RING: begin
        if (!idle) begin
          m_calls[m_owner]++;
          m_phase = TALK;
        end else begin
          // the line may stay idle for WAIT_MAX+1 cycles before the attempt is dropped
          m_idle_waits++;
          if (m_idle_waits > WAIT_MAX) m_phase = FREE;
        end
      end
      TALK: begin
        if (idle) m_phase = FREE;
        else if (hu[m_owner] || !rq[m_owner]) begin
          m_phase = CLEAR;
          m_end   = 1'b1;
        end
      end
      CLEAR: if (idle) m_phase = FREE;
      default: m_phase = FREE;
    endcase
  endtask

  function automatic logic [40:0] model_out();
    logic [3:0]  g;
    logic [31:0] c;
    g = (m_phase != FREE) ? 4'(1 << m_owner) : 4'b0;
    for (int i = 0; i < 4; i++) c[8*i +: 8] = (m_calls[i] > 255) ? 8'd255 : 8'(m_calls[i]);
    return {m_start, m_end, g, 2'(m_owner), (m_phase != FREE), c};
  endfunction

  task automatic drive(input bit r, input logic [3:0] rq, input logic [3:0] hu, input bit idle, input int tag);
    exp_t e;
    @(negedge clk);
    rst       = r;
    req       = rq;
    hangup    = hu;
    line_idle = idle;
    model_step(r, rq, hu, idle);
    e.v   = model_out();
    e.tag = tag;
    e.cyc = ncyc;
    ncyc++;
    exp_q.push_back(e);
  endtask

  // Stimulus
  initial begin
    logic [3:0] rq;
    logic [3:0] hu;
    rst = 1'b1; req = 4'b0; hangup = 4'b0; line_idle = 1'b1;

    drive(1, 4'b0000, 4'b0000, 1, 1);
    drive(1, 4'b0000, 4'b0000, 1, 1);
    drive(0, 4'b0101, 4'b0000, 1, 1);
    drive(0, 4'b0101, 4'b0000, 1, 1);
    drive(0, 4'b0101, 4'b0000, 0, 1);
    drive(0, 4'b0101, 4'b0000, 0, 1);
    drive(0, 4'b0101, 4'b0000, 1, 1);
    drive(0, 4'b0101, 4'b0000, 1, 1);
    drive(0, 4'b0101, 4'b0000, 1, 1);
    drive(0, 4'b0101, 4'b0000, 0, 1);
    drive(0, 4'b0101, 4'b0100, 0, 1);
    drive(0, 4'b0101, 4'b0000, 0, 1);
    drive(0, 4'b0101, 4'b0000, 0, 1);
    drive(0, 4'b0101, 4'b0000, 1, 1);
    drive(0, 4'b0101, 4'b0000, 1, 1);
    drive(0, 4'b0101, 4'b0000, 1, 1);
    drive(0, 4'b0101, 4'b0000, 0, 1);
    drive(0, 4'b0101, 4'b0001, 1, 1);
    drive(0, 4'b0000, 4'b0000, 1, 1);

    drive(1, 4'b0000, 4'b0000, 1, 2);
    for (int i = 0; i < 40; i++)
      drive(0, 4'($urandom_range(1, 15)), 4'($urandom), 1, 2);

    rq = 4'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      hu = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      drive(($urandom_range(0, 199) == 0), rq, hu, 1'($urandom), 3);
    end

    drive(1, 4'b0000, 4'b0000, 1, 4);
    for (int i = 0; i < 270; i++) begin
      drive(0, 4'b0010, 4'b0000, 1, 4);
      drive(0, 4'b0010, 4'b0000, 1, 4);
      drive(0, 4'b0010, 4'b0000, 0, 4);
      drive(0, 4'b0010, 4'b0000, 1, 4);
    end

    drive(0, 4'b1000, 4'b0000, 1, 5);
    drive(0, 4'b1000, 4'b0000, 1, 5);
    drive(0, 4'b1000, 4'b0000, 0, 5);
    drive(0, 4'b1000, 4'b0000, 0, 5);
    drive(1, 4'b1000, 4'b0000, 0, 5);
    drive(0, 4'b0000, 4'b0000, 0, 5);
    drive(0, 4'b0001, 4'b0000, 1, 5);
    drive(0, 4'b0001, 4'b0000, 1, 5);

    @(negedge clk);
    stim_done = 1'b1;
  end

  // Monitor: compares every presented output cycle against the queued prediction
  initial begin
    exp_t        e;
    logic [40:0] got;
    int          budget;
    budget = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {start_call, end_call, grant, owner, busy, call_cnt};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s cyc=%0d got start=%b end=%b grant=%b owner=%0d busy=%b cnt=%h exp start=%b end=%b grant=%b owner=%0d busy=%b cnt=%h",
                   tag_name(e.tag), e.cyc, got[40], got[39], got[38:35], got[34:33], got[32], got[31:0],
                   e.v[40], e.v[39], e.v[38:35], e.v[34:33], e.v[32], e.v[31:0]);
        end
      end else if (stim_done) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      budget++;
      if (budget > 20000) begin
        errors++;
        $display("FAIL run_budget cycles=%0d limit=20000", budget);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

endmodule
